// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit for the 16-bit datapath: fetch/decode/exec/mem/branch sequencing, PC owner.
// ALU/branch/store take MEM_LAT+2 cycles and loads 2*MEM_LAT+3; there is no handshake, only fixed memory latency.
module cpu_control_fsm #(
  parameter int          PC_W     = 16,
  parameter int          MEM_LAT  = 1,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     mem_rdata,
  input  logic [15:0]     reg_a,
  input  logic [15:0]     reg_b,
  input  logic [4:0]      flags,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_we,
  output logic            periph_sel,
  output logic [3:0]      reg_rd_a,
  output logic [3:0]      reg_rd_b,
  output logic [3:0]      reg_wr,
  output logic            reg_we,
  output logic            wb_sel,
  output logic [3:0]      alu_opcode,
  output logic            use_imm,
  output logic [15:0]     imm,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_LDW    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_BRANCH = 3'd6;
  localparam logic [2:0] S_HALT   = 3'd7;

  localparam logic [3:0] OP_RTYPE  = 4'h0;
  localparam logic [3:0] OP_MEMX   = 4'h4;
  localparam logic [3:0] OP_BCOND  = 4'hC;
  localparam logic [3:0] OP_HALT   = 4'hF;
  localparam logic [3:0] EXT_LOAD  = 4'h0;
  localparam logic [3:0] EXT_STOR  = 4'h4;
  localparam logic [3:0] EXT_JCOND = 4'hC;

  localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

  logic [2:0]  state;
  logic [1:0]  wait_cnt;
  logic [15:0] ir;

  logic [3:0] op;
  logic [3:0] rd;
  logic [3:0] ext;
  logic [3:0] rs;

  assign op  = ir[15:12];
  assign rd  = ir[11:8];
  assign ext = ir[7:4];
  assign rs  = ir[3:0];

  logic is_rtype;
  logic is_memx;
  logic is_load;
  logic is_stor;
  logic is_jcond;
  logic is_nop;
  logic is_bcond;
  logic is_halt;
  logic is_itype;

  always_comb begin
    is_rtype = (op == OP_RTYPE);
    is_memx  = (op == OP_MEMX);
    is_bcond = (op == OP_BCOND);
    is_halt  = (op == OP_HALT);
    is_load  = is_memx && (ext == EXT_LOAD);
    is_stor  = is_memx && (ext == EXT_STOR);
    is_jcond = is_memx && (ext == EXT_JCOND);
    is_nop   = is_memx && !is_load && !is_stor && !is_jcond;
    is_itype = !(is_rtype || is_memx || is_bcond || is_halt);
  end

  // flags = {C,L,F,Z,N}; the condition code lives in the rd field
  logic cond_true;
  always_comb begin
    cond_true = 1'b0;
    case (rd)
      4'd0:    cond_true =  flags[1];
      4'd1:    cond_true = !flags[1];
      4'd2:    cond_true =  flags[4];
      4'd3:    cond_true = !flags[4];
      4'd4:    cond_true =  flags[3];
      4'd5:    cond_true = !flags[3];
      4'd6:    cond_true =  flags[0];
      4'd7:    cond_true = !flags[0];
      4'd8:    cond_true =  flags[2];
      4'd9:    cond_true = !flags[2];
      4'd14:   cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] jmp_target;
  logic            last_wait;

  assign imm        = {{8{ir[7]}}, ir[7:0]};
  assign pc_inc     = pc + PC_W'(1);
  assign br_target  = pc + imm[PC_W-1:0];
  assign jmp_target = reg_b[PC_W-1:0];
  assign last_wait  = (wait_cnt == LAT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= 2'd0;
      ir       <= 16'h0000;
      pc       <= RESET_PC[PC_W-1:0];
    end else begin
      case (state)
        S_FETCH: begin
          if (last_wait) begin
            ir       <= mem_rdata;
            wait_cnt <= 2'd0;
            state    <= S_DECODE;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        S_DECODE: begin
          if (is_halt)
            state <= S_HALT;
          else if (is_load || is_stor)
            state <= S_MEM;
          else if (is_bcond || is_jcond)
            state <= S_BRANCH;
          else
            state <= S_EXEC;
        end
        S_EXEC: begin
          pc    <= pc_inc;
          state <= S_FETCH;
        end
        S_MEM: begin
          if (is_stor) begin
            pc    <= pc_inc;
            state <= S_FETCH;
          end else if (last_wait) begin
            wait_cnt <= 2'd0;
            state    <= S_LDW;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        // read data for the final MEM address settles on mem_rdata during this cycle
        S_LDW: state <= S_WB;
        S_WB: begin
          pc    <= pc_inc;
          state <= S_FETCH;
        end
        S_BRANCH: begin
          if (cond_true)
            pc <= is_jcond ? jmp_target : br_target;
          else
            pc <= pc_inc;
          state <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // strobes are masked by reset so a reset landing mid-instruction never pulses a write
  always_comb begin
    mem_addr   = (state == S_MEM) ? reg_b[PC_W-1:0] : pc;
    periph_sel = !reset && (state == S_MEM) && reg_b[PC_W-1];
    mem_we     = !reset && (state == S_MEM) && is_stor && !reg_b[PC_W-1];
    reg_we     = !reset && (((state == S_EXEC) && !is_nop) || (state == S_WB));
    wb_sel     = (state == S_WB);
    halted     = (state == S_HALT);
    use_imm    = is_itype;
    alu_opcode = is_rtype ? ext : op;
    reg_rd_a   = rd;
    reg_rd_b   = rs;
    reg_wr     = rd;
  end

  // store data travels from reg_a straight to the memory port, not through this block
  logic unused_inputs;
  assign unused_inputs = ^{reg_a, reg_b};

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: three instances at MEM_LAT 1/2/3 share one program memory.
module tb_cpu_control_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] reg_a = 16'h5A5A;
  logic [15:0] reg_b = 16'h0000;
  logic [4:0]  flags = 5'b00000;
  logic [15:0] imem [256];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // u1: MEM_LAT=1, PC_W=16
  logic [15:0] u1_rdata, u1_imm, u1_addr, u1_pc;
  logic [3:0]  u1_rd_a, u1_rd_b, u1_wr, u1_alu;
  logic        u1_mem_we, u1_periph, u1_reg_we, u1_wb_sel, u1_use_imm, u1_halted;
  assign u1_rdata = imem[u1_addr[7:0]];

  cpu_control_fsm #(.PC_W(16), .MEM_LAT(1), .RESET_PC(16'h0000)) u1 (
    .clk(clk), .reset(reset), .mem_rdata(u1_rdata), .reg_a(reg_a), .reg_b(reg_b), .flags(flags),
    .mem_addr(u1_addr), .mem_we(u1_mem_we), .periph_sel(u1_periph), .reg_rd_a(u1_rd_a), .reg_rd_b(u1_rd_b),
    .reg_wr(u1_wr), .reg_we(u1_reg_we), .wb_sel(u1_wb_sel), .alu_opcode(u1_alu), .use_imm(u1_use_imm),
    .imm(u1_imm), .pc(u1_pc), .halted(u1_halted));

  // u2: MEM_LAT=2, PC_W=9
  logic [15:0] u2_rdata, u2_unused_imm;
  logic [8:0]  u2_addr, u2_pc;
  logic [3:0]  u2_unused_rd_a, u2_unused_rd_b, u2_wr, u2_unused_alu;
  logic        u2_mem_we, u2_periph, u2_reg_we, u2_wb_sel, u2_use_imm, u2_halted;
  assign u2_rdata = imem[u2_addr[7:0]];

  cpu_control_fsm #(.PC_W(9), .MEM_LAT(2), .RESET_PC(16'h0000)) u2 (
    .clk(clk), .reset(reset), .mem_rdata(u2_rdata), .reg_a(reg_a), .reg_b(reg_b), .flags(flags),
    .mem_addr(u2_addr), .mem_we(u2_mem_we), .periph_sel(u2_periph), .reg_rd_a(u2_unused_rd_a),
    .reg_rd_b(u2_unused_rd_b), .reg_wr(u2_wr), .reg_we(u2_reg_we), .wb_sel(u2_wb_sel),
    .alu_opcode(u2_unused_alu), .use_imm(u2_use_imm), .imm(u2_unused_imm), .pc(u2_pc), .halted(u2_halted));

  // u3: MEM_LAT=3, PC_W=16
  logic [15:0] u3_rdata, u3_unused_imm, u3_addr, u3_pc;
  logic [3:0]  u3_unused_rd_a, u3_unused_rd_b, u3_wr, u3_unused_alu;
  logic        u3_mem_we, u3_periph, u3_reg_we, u3_wb_sel, u3_unused_use_imm, u3_unused_halted;
  assign u3_rdata = imem[u3_addr[7:0]];

  cpu_control_fsm #(.PC_W(16), .MEM_LAT(3), .RESET_PC(16'h0000)) u3 (
    .clk(clk), .reset(reset), .mem_rdata(u3_rdata), .reg_a(reg_a), .reg_b(reg_b), .flags(flags),
    .mem_addr(u3_addr), .mem_we(u3_mem_we), .periph_sel(u3_periph), .reg_rd_a(u3_unused_rd_a),
    .reg_rd_b(u3_unused_rd_b), .reg_wr(u3_wr), .reg_we(u3_reg_we), .wb_sel(u3_wb_sel),
    .alu_opcode(u3_unused_alu), .use_imm(u3_unused_use_imm), .imm(u3_unused_imm), .pc(u3_pc),
    .halted(u3_unused_halted));

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
  endtask

  // leaves the bench inside the first FETCH cycle with reset low
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    int seen;
    int bad_we;
    logic wbs;
    logic [3:0] wr;
    clear_mem();
    imem[0] = 16'h4304;             // LOAD r3,[r4]
    reg_b = 16'h0020;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_cmp++; if (u2_pc !== 9'd0) begin n_bad++; $display("FAIL rst_pc: got %h want 000", u2_pc); end
    n_cmp++; if ({u2_mem_we, u2_reg_we, u2_periph, u2_wb_sel, u2_use_imm, u2_halted} !== 6'b0) begin
      n_bad++; $display("FAIL rst_outs: got %b want 000000",
                        {u2_mem_we, u2_reg_we, u2_periph, u2_wb_sel, u2_use_imm, u2_halted}); end
    reset = 1'b0; #1;
    tick(); tick(); tick();         // cycle 4: first MEM cycle
    n_cmp++; if (u2_addr !== 9'h020) begin n_bad++; $display("FAIL rst_midmem_addr: got %h want 020", u2_addr); end
    reset = 1'b1; #1;
    n_cmp++; if ({u2_reg_we, u2_mem_we} !== 2'b00) begin
      n_bad++; $display("FAIL rst_strobe_mem: got %b want 00", {u2_reg_we, u2_mem_we}); end
    tick();
    n_cmp++; if (u2_pc !== 9'd0 || u2_addr !== 9'd0) begin
      n_bad++; $display("FAIL rst_to_fetch: pc %h addr %h want 000/000", u2_pc, u2_addr); end
    n_cmp++; if ({u2_reg_we, u2_mem_we} !== 2'b00) begin
      n_bad++; $display("FAIL rst_strobe_fetch: got %b want 00", {u2_reg_we, u2_mem_we}); end
    reset = 1'b0; #1;
    seen = 0; bad_we = 0; wbs = 1'b0; wr = 4'h0;
    for (int k = 1; k <= 12; k++) begin
      if (u2_mem_we) bad_we++;
      if (u2_reg_we && seen == 0) begin seen = k; wbs = u2_wb_sel; wr = u2_wr; end
      tick();
    end
    n_cmp++; if (seen != 7) begin n_bad++; $display("FAIL rst_reload_wb_cycle: got %0d want 7", seen); end
    n_cmp++; if ({wbs, wr} !== 5'b1_0011) begin n_bad++; $display("FAIL rst_reload_wb: got %b want 10011", {wbs, wr}); end
    n_cmp++; if (bad_we != 0) begin n_bad++; $display("FAIL rst_reload_mem_we: got %0d want 0", bad_we); end
  endtask

  task automatic test_alu();
    clear_mem();
    imem[0] = 16'h0152;             // RTYPE ext=5 r1,r2
    imem[1] = 16'h1785;             // ITYPE op=1 r7, imm 0x85
    do_reset();
    n_cmp++; if (u1_addr !== 16'h0000 || u1_reg_we !== 1'b0) begin
      n_bad++; $display("FAIL alu_c1: addr %h we %b want 0000/0", u1_addr, u1_reg_we); end
    tick();
    n_cmp++; if ({u1_rd_a, u1_rd_b} !== 8'h12) begin n_bad++; $display("FAIL alu_rdsel: got %h want 12", {u1_rd_a, u1_rd_b}); end
    tick();
    n_cmp++; if ({u1_reg_we, u1_wr, u1_alu, u1_use_imm, u1_wb_sel} !== 11'b1_0001_0101_0_0) begin
      n_bad++; $display("FAIL rtype_exec: got %b want 10001010100", {u1_reg_we, u1_wr, u1_alu, u1_use_imm, u1_wb_sel}); end
    n_cmp++; if (u1_pc !== 16'h0000) begin n_bad++; $display("FAIL rtype_pc_c3: got %h want 0000", u1_pc); end
    tick();
    n_cmp++; if (u1_pc !== 16'h0001 || u1_reg_we !== 1'b0) begin
      n_bad++; $display("FAIL rtype_pc_c4: pc %h we %b want 0001/0", u1_pc, u1_reg_we); end
    tick(); tick();
    n_cmp++; if ({u1_reg_we, u1_wr, u1_alu, u1_use_imm} !== 10'b1_0111_0001_1) begin
      n_bad++; $display("FAIL itype_exec: got %b want 1011100011", {u1_reg_we, u1_wr, u1_alu, u1_use_imm}); end
    n_cmp++; if (u1_imm !== 16'hFF85) begin n_bad++; $display("FAIL itype_imm: got %h want ff85", u1_imm); end
    tick();
    n_cmp++; if (u1_pc !== 16'h0002) begin n_bad++; $display("FAIL itype_pc: got %h want 0002", u1_pc); end
  endtask

  task automatic test_load();
    clear_mem();
    imem[0] = 16'h4304;
    imem[8'h20] = 16'hBEEF;
    reg_b = 16'h0020;
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      n_cmp++; if (u3_addr !== 16'h0000) begin n_bad++; $display("FAIL load_fetch_addr c%0d: got %h want 0000", k, u3_addr); end
      tick();
    end
    tick();                         // cycle 5
    for (int k = 5; k <= 7; k++) begin
      n_cmp++; if (u3_addr !== 16'h0020 || {u3_mem_we, u3_periph, u3_reg_we} !== 3'b000) begin
        n_bad++; $display("FAIL load_mem c%0d: addr %h strobes %b want 0020/000", k, u3_addr, {u3_mem_we, u3_periph, u3_reg_we}); end
      tick();
    end
    n_cmp++; if (u3_reg_we !== 1'b0) begin n_bad++; $display("FAIL load_c8_we: got %b want 0", u3_reg_we); end
    tick();
    n_cmp++; if ({u3_reg_we, u3_wb_sel, u3_wr, u3_mem_we} !== 7'b1_1_0011_0) begin
      n_bad++; $display("FAIL load_wb: got %b want 1100110", {u3_reg_we, u3_wb_sel, u3_wr, u3_mem_we}); end
    tick();
    n_cmp++; if (u3_pc !== 16'h0001 || {u3_reg_we, u3_wb_sel} !== 2'b00) begin
      n_bad++; $display("FAIL load_done: pc %h we/wb %b want 0001/00", u3_pc, {u3_reg_we, u3_wb_sel}); end
  endtask

  task automatic test_store();
    clear_mem();
    imem[0] = 16'h4546;             // STOR r5,[r6]
    imem[1] = 16'h4546;
    reg_b = 16'h8010;
    do_reset();
    tick(); tick();
    n_cmp++; if ({u1_periph, u1_mem_we, u1_reg_we} !== 3'b100 || u1_addr !== 16'h8010) begin
      n_bad++; $display("FAIL stor_periph: strobes %b addr %h want 100/8010", {u1_periph, u1_mem_we, u1_reg_we}, u1_addr); end
    tick();
    n_cmp++; if (u1_pc !== 16'h0001 || {u1_periph, u1_mem_we} !== 2'b00) begin
      n_bad++; $display("FAIL stor_periph_done: pc %h strobes %b want 0001/00", u1_pc, {u1_periph, u1_mem_we}); end
    reg_b = 16'h0030;
    tick(); tick();
    n_cmp++; if ({u1_mem_we, u1_periph, u1_reg_we} !== 3'b100 || u1_addr !== 16'h0030) begin
      n_bad++; $display("FAIL stor_mem: strobes %b addr %h want 100/0030", {u1_mem_we, u1_periph, u1_reg_we}, u1_addr); end
    tick();
    n_cmp++; if (u1_pc !== 16'h0002 || u1_mem_we !== 1'b0) begin
      n_bad++; $display("FAIL stor_mem_done: pc %h we %b want 0002/0", u1_pc, u1_mem_we); end
  endtask

  task automatic test_branch();
    clear_mem();
    imem[0] = 16'h4010;             // op4 unknown ext -> NOP
    imem[1] = 16'hC0FE;             // BCOND EQ, -2
    imem[2] = 16'h4EC1;             // JCOND UC, reg_b
    imem[8'h34] = 16'hCF10;         // BCOND never, +16
    flags = 5'b00010;
    do_reset();
    tick(); tick();
    n_cmp++; if (u1_reg_we !== 1'b0) begin n_bad++; $display("FAIL nop_we: got %b want 0", u1_reg_we); end
    tick();
    n_cmp++; if (u1_pc !== 16'h0001) begin n_bad++; $display("FAIL nop_pc: got %h want 0001", u1_pc); end
    tick(); tick();
    n_cmp++; if ({u1_reg_we, u1_mem_we, u1_periph} !== 3'b000) begin
      n_bad++; $display("FAIL branch_strobes: got %b want 000", {u1_reg_we, u1_mem_we, u1_periph}); end
    tick();
    n_cmp++; if (u1_pc !== 16'hFFFF) begin n_bad++; $display("FAIL bcond_taken_wrap: got %h want ffff", u1_pc); end
    flags = 5'b00000;
    reg_b = 16'h1234;
    do_reset();
    repeat (6) tick();
    n_cmp++; if (u1_pc !== 16'h0002) begin n_bad++; $display("FAIL bcond_not_taken: got %h want 0002", u1_pc); end
    repeat (3) tick();
    n_cmp++; if (u1_pc !== 16'h1234) begin n_bad++; $display("FAIL jcond_uc: got %h want 1234", u1_pc); end
    repeat (3) tick();
    n_cmp++; if (u1_pc !== 16'h1235) begin n_bad++; $display("FAIL bcond_never: got %h want 1235", u1_pc); end
  endtask

  task automatic test_halt();
    int at;
    int bad;
    clear_mem();
    for (int i = 0; i < 5; i++) imem[i] = 16'h4010;
    imem[5] = 16'hF000;
    do_reset();
    at = 0;
    for (int k = 1; k <= 40; k++) begin
      if (u1_halted && at == 0) at = k;
      if (at == 0) tick();
    end
    n_cmp++; if (at != 18) begin n_bad++; $display("FAIL halt_cycle: got %0d want 18", at); end
    n_cmp++; if (u1_pc !== 16'h0005) begin n_bad++; $display("FAIL halt_pc: got %h want 0005", u1_pc); end
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (!u1_halted || u1_pc !== 16'h0005 || u1_reg_we || u1_mem_we || u1_periph) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL halt_hold: %0d bad cycles want 0", bad); end
    reset = 1'b1;
    tick();
    n_cmp++; if (u1_pc !== 16'h0000 || u1_halted !== 1'b0) begin
      n_bad++; $display("FAIL halt_reset: pc %h halted %b want 0000/0", u1_pc, u1_halted); end
    reset = 1'b0;
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench still running at %0t want finished", $time);
    $fatal(1, "watchdog");
  end

endmodule
